// File: rtl/host_status_wr_pkg.sv
// Shared TLP constants, TX FSM state encoding and header helpers for the
// host status write-back master.
package host_status_wr_pkg;

  localparam logic [6:0] MEM_WR32_FMT_TYPE = 7'h40;
  localparam logic [6:0] MEM_WR64_FMT_TYPE = 7'h60;

  localparam logic [2:0] TLP_TC_DW0    = 3'b000;
  localparam logic       TLP_TD_DW0    = 1'b0;
  localparam logic       TLP_EP_DW0    = 1'b0;
  localparam logic [1:0] TLP_ATTR_DW0  = 2'b00;
  localparam logic [9:0] TLP_LEN1_DW0  = 10'd1;

  localparam logic [3:0] TLP_LAST_BE   = 4'h0;
  localparam logic [3:0] TLP_FIRST_BE  = 4'hF;

  localparam logic [7:0] TREM_BOTH     = 8'h00;
  localparam logic [7:0] TREM_UPPER    = 8'h0F;
  localparam logic [7:0] TREM_IDLE     = 8'hFF;

  typedef enum logic [2:0] {
    IDLE, ARB, CHK, WBUF, B0, B1, B2
  } state_t;

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [31:0] mem_wr_dw0(input logic [6:0] fmt_type);
    return {1'b0, fmt_type, 1'b0, TLP_TC_DW0, 4'b0000, TLP_TD_DW0, TLP_EP_DW0,
            TLP_ATTR_DW0, 2'b00, TLP_LEN1_DW0};
  endfunction

endpackage

// File: rtl/host_status_wr.sv
// Bus-master transmitter: one 1-DW posted Memory Write of status_val to
// host_addr per trigger, sharing the TRN TX link via req_ep/my_turn.
module host_status_wr
  import host_status_wr_pkg::*;
#(
  parameter logic [7:0] TAG        = 8'h00,
  parameter bit         SWAP_BYTES = 1'b1
) (
  input  logic        trn_clk,
  input  logic        reset,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [3:0]  trn_tbuf_av,
  input  logic [15:0] cfg_completer_id,
  input  logic        cfg_bus_mstr_enable,
  input  logic [63:0] host_addr,
  input  logic [31:0] status_val,
  input  logic        trigger,
  output logic        busy,
  output logic        done,
  input  logic        my_turn,
  output logic        req_ep,
  output logic        driving_interface
);

  state_t      state, state_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] val_q, val_d;
  logic        pending, pending_d;
  logic [63:0] td_d;
  logic [7:0]  trem_d;
  logic        sof_d, eof_d, rdy_d;
  logic        req_d, drv_d, done_d, busy_d;
  logic        finish;

  logic        fmt64;
  logic [31:0] payload;
  logic [63:0] beat0, beat1, beat2;
  logic        unused_ok;

  assign trn_tsrc_dsc_n = 1'b1;
  assign unused_ok      = ^{trn_tbuf_av[3:2], trn_tbuf_av[0], addr_q[1:0]};

  assign fmt64   = |addr_q[63:32];
  assign payload = SWAP_BYTES ? swap32(val_q) : val_q;
  assign beat0   = {mem_wr_dw0(fmt64 ? MEM_WR64_FMT_TYPE : MEM_WR32_FMT_TYPE),
                    cfg_completer_id, TAG, TLP_LAST_BE, TLP_FIRST_BE};
  assign beat1   = fmt64 ? {addr_q[63:32], addr_q[31:2], 2'b00}
                         : {addr_q[31:2], 2'b00, payload};
  assign beat2   = {payload, 32'h0};

  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    val_d     = val_q;
    pending_d = pending | (trigger && (state != IDLE));
    td_d      = trn_td;
    trem_d    = trn_trem_n;
    sof_d     = trn_tsof_n;
    eof_d     = trn_teof_n;
    rdy_d     = trn_tsrc_rdy_n;
    req_d     = req_ep;
    drv_d     = driving_interface;
    done_d    = 1'b0;
    busy_d    = busy;
    finish    = 1'b0;

    case (state)
      IDLE: begin
        if ((trigger || pending) && cfg_bus_mstr_enable) begin
          addr_d    = host_addr;
          val_d     = status_val;
          pending_d = 1'b0;
          req_d     = 1'b1;
          busy_d    = 1'b1;
          state_d   = ARB;
        end else if (trigger) begin
          pending_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ARB: begin
        if (my_turn) begin
          req_d   = 1'b0;
          drv_d   = 1'b1;
          state_d = CHK;
        end
      end
      CHK: begin
        if (trn_tbuf_av[1]) begin
          td_d    = beat0;
          trem_d  = TREM_BOTH;
          sof_d   = 1'b0;
          eof_d   = 1'b1;
          rdy_d   = 1'b0;
          state_d = B0;
        end else begin
          drv_d   = 1'b0;
          state_d = WBUF;
        end
      end
      WBUF: begin
        if (trn_tbuf_av[1]) begin
          req_d   = 1'b1;
          state_d = ARB;
        end
      end
      B0: begin
        if (!trn_tdst_rdy_n) begin
          td_d    = beat1;
          trem_d  = TREM_BOTH;
          sof_d   = 1'b1;
          eof_d   = fmt64;
          state_d = B1;
        end
      end
      B1: begin
        if (!trn_tdst_rdy_n) begin
          if (fmt64) begin
            td_d    = beat2;
            trem_d  = TREM_UPPER;
            eof_d   = 1'b0;
            state_d = B2;
          end else begin
            finish = 1'b1;
          end
        end
      end
      B2: begin
        if (!trn_tdst_rdy_n) finish = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // busy follows the next pending so a trigger seen on the finish edge keeps it high
    if (finish) begin
      rdy_d   = 1'b1;
      sof_d   = 1'b1;
      eof_d   = 1'b1;
      drv_d   = 1'b0;
      done_d  = 1'b1;
      busy_d  = pending_d;
      state_d = IDLE;
    end
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state             <= IDLE;
      addr_q            <= '0;
      val_q             <= '0;
      pending           <= 1'b0;
      trn_td            <= '0;
      trn_trem_n        <= TREM_IDLE;
      trn_tsof_n        <= 1'b1;
      trn_teof_n        <= 1'b1;
      trn_tsrc_rdy_n    <= 1'b1;
      req_ep            <= 1'b0;
      driving_interface <= 1'b0;
      done              <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_d;
      addr_q            <= addr_d;
      val_q             <= val_d;
      pending           <= pending_d;
      trn_td            <= td_d;
      trn_trem_n        <= trem_d;
      trn_tsof_n        <= sof_d;
      trn_teof_n        <= eof_d;
      trn_tsrc_rdy_n    <= rdy_d;
      req_ep            <= req_d;
      driving_interface <= drv_d;
      done              <= done_d;
      busy              <= busy_d;
    end
  end

endmodule

// File: tb/tb_host_status_wr.sv
// Directed self-checking bench for host_status_wr.
module tb_host_status_wr;

  logic        trn_clk;
  logic        reset;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n;
  logic [3:0]  trn_tbuf_av;
  logic [15:0] cfg_completer_id;
  logic        cfg_bus_mstr_enable;
  logic [63:0] host_addr;
  logic [31:0] status_val;
  logic        trigger, busy, done, my_turn, req_ep, driving_interface;
  logic        grant_en;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] td;
    logic [7:0]  trem;
    logic        sof;
    logic        eof;
  } beat_t;

  beat_t beats[$];
  int    done_cnt = 0;
  int    req_seen = 0;

  host_status_wr #(.TAG(8'h00), .SWAP_BYTES(1'b1)) dut (
    .trn_clk(trn_clk), .reset(reset),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n),
    .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
    .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
    .cfg_completer_id(cfg_completer_id), .cfg_bus_mstr_enable(cfg_bus_mstr_enable),
    .host_addr(host_addr), .status_val(status_val), .trigger(trigger),
    .busy(busy), .done(done), .my_turn(my_turn), .req_ep(req_ep),
    .driving_interface(driving_interface)
  );

  assign my_turn = grant_en & req_ep;

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  always @(negedge trn_clk) begin
    beat_t b;
    if (!reset && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
      b.td   = trn_td;
      b.trem = trn_trem_n;
      b.sof  = ~trn_tsof_n;
      b.eof  = ~trn_teof_n;
      beats.push_back(b);
    end
    if (done) done_cnt++;
    if (req_ep) req_seen++;
  end

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!ok) begin
        tick();
        if (done) ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (trn_td !== 64'h0) begin failures++; $display("FAIL reset_td got=%h exp=0", trn_td); end
    checks++;
    if (trn_trem_n !== 8'hFF) begin failures++; $display("FAIL reset_trem got=%h exp=ff", trn_trem_n); end
    checks++;
    if ({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n} !== 4'b1111) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=1111", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n});
    end
    checks++;
    if ({req_ep, driving_interface, done, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_hs got=%b exp=0000", {req_ep, driving_interface, done, busy});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_wr32();
    int base = beats.size();
    int d0 = done_cnt;
    bit ok;
    host_addr  = 64'h0000_0000_1234_5670;
    status_val = 32'hA1B2C3D4;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    tick();
    checks++;
    if ({trn_tsrc_rdy_n, trn_tsof_n} !== 2'b00 || trn_td !== 64'h4000_0001_BEEF_000F) begin
      failures++;
      $display("FAIL wr32_latency rdy/sof=%b td=%h exp 00 4000_0001_beef_000f", {trn_tsrc_rdy_n, trn_tsof_n}, trn_td);
    end
    wait_done(40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wr32_done_timeout got=0 exp=1"); end
    tick();
    tick();
    checks++;
    if (beats.size() - base !== 2) begin failures++; $display("FAIL wr32_beats got=%0d exp=2", beats.size() - base); end
    else begin
      checks++;
      if (beats[base] !== {64'h4000_0001_BEEF_000F, 8'h00, 1'b1, 1'b0}) begin
        failures++; $display("FAIL wr32_b0 got=%h exp=4000_0001_beef_000f/00/sof", beats[base]);
      end
      checks++;
      if (beats[base+1] !== {64'h1234_5670_D4C3_B2A1, 8'h00, 1'b0, 1'b1}) begin
        failures++; $display("FAIL wr32_b1 got=%h exp=1234_5670_d4c3_b2a1/00/eof", beats[base+1]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      failures++; $display("FAIL wr32_done_once done=%0d busy=%b exp 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_wr64();
    int base = beats.size();
    bit ok;
    host_addr  = 64'h0000_0001_8000_0004;
    status_val = 32'h0000_0001;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_done(40, ok);
    tick();
    checks++;
    if (!ok || beats.size() - base !== 3) begin
      failures++; $display("FAIL wr64_beats got=%0d done=%b exp=3 1", beats.size() - base, ok);
    end else begin
      checks++;
      if (beats[base] !== {64'h6000_0001_BEEF_000F, 8'h00, 1'b1, 1'b0}) begin
        failures++; $display("FAIL wr64_b0 got=%h exp=6000_0001_beef_000f/00/sof", beats[base]);
      end
      checks++;
      if (beats[base+1] !== {64'h0000_0001_8000_0004, 8'h00, 1'b0, 1'b0}) begin
        failures++; $display("FAIL wr64_b1 got=%h exp=0000_0001_8000_0004/00", beats[base+1]);
      end
      checks++;
      if (beats[base+2] !== {64'h0100_0000_0000_0000, 8'h0F, 1'b0, 1'b1}) begin
        failures++; $display("FAIL wr64_b2 got=%h exp=0100_0000_0000_0000/0f/eof", beats[base+2]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base = beats.size();
    int d0 = done_cnt;
    logic [4:0] pat = 5'b01011;
    logic [75:0] snap;
    logic stalled;
    int stall_bad = 0;
    bit ok = 1'b0;
    host_addr  = 64'hFFFF_FFFF_0000_00FF;
    status_val = 32'h1122_3344;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!ok) begin
        trn_tdst_rdy_n = pat[i % 5];
        snap = {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n};
        stalled = !trn_tsrc_rdy_n && trn_tdst_rdy_n;
        tick();
        if (stalled && snap !== {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n})
          stall_bad++;
        if (done) ok = 1'b1;
      end
    end
    trn_tdst_rdy_n = 1'b0;
    tick();
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    checks++;
    if (stall_bad !== 0) begin failures++; $display("FAIL bp_stall_stable changes=%0d exp=0", stall_bad); end
    checks++;
    if (beats.size() - base !== 3 || done_cnt - d0 !== 1) begin
      failures++; $display("FAIL bp_beat_count beats=%0d done=%0d exp=3 1", beats.size() - base, done_cnt - d0);
    end else begin
      checks++;
      if (beats[base].td !== 64'h6000_0001_BEEF_000F || beats[base+1].td !== 64'hFFFF_FFFF_0000_00FC ||
          beats[base+2].td !== 64'h4433_2211_0000_0000) begin
        failures++;
        $display("FAIL bp_beats got=%h %h %h exp=6000_0001_beef_000f ffff_ffff_0000_00fc 4433_2211_0000_0000",
                 beats[base].td, beats[base+1].td, beats[base+2].td);
      end
    end
  endtask

  task automatic test_tbuf_wait();
    int base = beats.size();
    bit ok;
    host_addr   = 64'h0000_0000_0000_2000;
    status_val  = 32'h0000_00AA;
    trn_tbuf_av = 4'b1101;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    checks++;
    if (driving_interface !== 1'b1) begin failures++; $display("FAIL tbuf_grant drv=%b exp=1", driving_interface); end
    tick();
    checks++;
    if ({driving_interface, req_ep, trn_tsrc_rdy_n} !== 3'b001) begin
      failures++; $display("FAIL tbuf_wbuf drv/req/rdy=%b exp=001", {driving_interface, req_ep, trn_tsrc_rdy_n});
    end
    tick();
    tick();
    tick();
    checks++;
    if (driving_interface !== 1'b0 || beats.size() !== base) begin
      failures++; $display("FAIL tbuf_hold drv=%b beats=%0d exp 0 0", driving_interface, beats.size() - base);
    end
    trn_tbuf_av = 4'b1111;
    tick();
    checks++;
    if (req_ep !== 1'b1) begin failures++; $display("FAIL tbuf_rereq req=%b exp=1", req_ep); end
    wait_done(40, ok);
    tick();
    checks++;
    if (!ok || beats.size() - base !== 2 || beats[base+1].td !== 64'h0000_2000_AA00_0000) begin
      failures++; $display("FAIL tbuf_complete done=%b beats=%0d exp 1 2 0000_2000_aa00_0000", ok, beats.size() - base);
    end
  endtask

  task automatic test_back_to_back();
    int base = beats.size();
    int d0 = done_cnt;
    bit ok;
    host_addr  = 64'h0000_0000_0000_1000;
    status_val = 32'h0000_0010;
    trigger = 1'b1;
    tick();
    status_val = 32'h0000_0020;
    tick();
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    status_val = 32'hCAFE_0030;
    tick();
    tick();
    trigger = 1'b0;
    checks++;
    if ({done, busy, trn_tsrc_rdy_n} !== 3'b111) begin
      failures++; $display("FAIL b2b_gap done/busy/rdy=%b exp=111", {done, busy, trn_tsrc_rdy_n});
    end
    tick();
    status_val = 32'h5555_5555;
    checks++;
    if ({busy, req_ep} !== 2'b11) begin failures++; $display("FAIL b2b_restart busy/req=%b exp=11", {busy, req_ep}); end
    wait_done(40, ok);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (!ok || done_cnt - d0 !== 2 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_count done=%0d busy=%b exp 2 0", done_cnt - d0, busy);
    end
    checks++;
    if (beats.size() - base !== 4) begin failures++; $display("FAIL b2b_beats got=%0d exp=4", beats.size() - base); end
    else begin
      checks++;
      if (beats[base+1].td !== 64'h0000_1000_1000_0000 || beats[base+3].td !== 64'h0000_1000_3000_FECA) begin
        failures++;
        $display("FAIL b2b_payload got=%h %h exp=0000_1000_1000_0000 0000_1000_3000_feca",
                 beats[base+1].td, beats[base+3].td);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    host_addr      = 64'h0000_0000_0000_3000;
    status_val     = 32'h1234_5678;
    trn_tdst_rdy_n = 1'b1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    tick();
    trn_tdst_rdy_n = 1'b0;
    tick();
    trn_tdst_rdy_n = 1'b1;
    tick();
    checks++;
    if ({trn_tsrc_rdy_n, trn_teof_n} !== 2'b00) begin
      failures++; $display("FAIL rst_mid_in_b1 rdy/eof=%b exp=00", {trn_tsrc_rdy_n, trn_teof_n});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n,
         req_ep, driving_interface, done, busy} !== {64'h0, 8'hFF, 4'b1111, 4'b0000}) begin
      failures++;
      $display("FAIL rst_mid_outputs td=%h trem=%h ctl=%b hs=%b exp 0 ff 1111 0000", trn_td, trn_trem_n,
               {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n}, {req_ep, driving_interface, done, busy});
    end
    reset = 1'b0;
    trn_tdst_rdy_n = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0 || req_ep !== 1'b0) begin
      failures++; $display("FAIL rst_mid_no_done done=%0d busy=%b req=%b exp 0 0 0", done_cnt - d0, busy, req_ep);
    end
  endtask

  task automatic test_mstr_disable();
    int base = beats.size();
    int r0;
    bit ok;
    host_addr  = 64'h0000_0000_0000_4000;
    status_val = 32'h0000_BB00;
    cfg_bus_mstr_enable = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    r0 = req_seen;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (req_seen !== r0 || busy !== 1'b1) begin
      failures++; $display("FAIL mstr_hold req_cycles=%0d busy=%b exp 0 1", req_seen - r0, busy);
    end
    cfg_bus_mstr_enable = 1'b1;
    tick();
    checks++;
    if (req_ep !== 1'b1) begin failures++; $display("FAIL mstr_enable_req req=%b exp=1", req_ep); end
    wait_done(40, ok);
    tick();
    checks++;
    if (!ok || beats.size() - base !== 2 || beats[base+1].td !== 64'h0000_4000_00BB_0000) begin
      failures++; $display("FAIL mstr_tlp done=%b beats=%0d exp 1 2 0000_4000_00bb_0000", ok, beats.size() - base);
    end
  endtask

  initial begin
    reset = 1'b1;
    trigger = 1'b0;
    trn_tdst_rdy_n = 1'b0;
    trn_tbuf_av = 4'hF;
    cfg_completer_id = 16'hBEEF;
    cfg_bus_mstr_enable = 1'b1;
    grant_en = 1'b1;
    host_addr = '0;
    status_val = '0;
    test_reset();
    test_wr32();
    test_wr64();
    test_backpressure();
    test_tbuf_wait();
    test_back_to_back();
    test_reset_mid();
    test_mstr_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
